// File: rtl/memory_lsu.sv
`default_nettype none
// ============================================================================
// Module   : memory_lsu
// Purpose  : Load/store stage after the execute ALU. Issues data-memory
//            transactions over req/gnt + rvld, aligns and extends load data,
//            and emits one registered writeback beat per instruction.
// Revision : 1.0 - initial release
// ============================================================================
module memory_lsu #(
   parameter int         XLEN      = 32,
   parameter logic [6:0] OP_LOAD   = 7'b0000011,
   parameter logic [6:0] OP_STORE  = 7'b0100011,
   parameter logic [6:0] OP_BRANCH = 7'b1100011
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_vld,
   output logic            ex_rdy,
   input  logic [6:0]      ex_opcode,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_alu_y,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [4:0]      ex_rd,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvld,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            wb_vld,
   output logic            wb_we,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            lsu_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic              wb_vld_q, wb_vld_d;
   logic              wb_we_q, wb_we_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic              lsu_err_q, lsu_err_d;
   // Load context kept across the transaction for formatting the response
   logic [2:0]        ld_f3_q, ld_f3_d;
   logic [1:0]        ld_off_q, ld_off_d;
   logic [4:0]        rd_q, rd_d;

   logic              is_load, is_store, f3_bad, misaligned;
   logic [1:0]        a;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [XLEN-1:0]   ld_fmt;

   // Decode memory-op legality of the presented instruction
   always_comb begin
      a          = ex_alu_y[1:0];
      is_load    = (ex_opcode == OP_LOAD);
      is_store   = (ex_opcode == OP_STORE);
      f3_bad     = is_load ? ((ex_funct3 == 3'd3) || (ex_funct3 == 3'd6) || (ex_funct3 == 3'd7))
                           : (ex_funct3 > 3'd2);
      misaligned = 1'b0;
      case (ex_funct3[1:0])
         2'd1:    misaligned = a[0];
         2'd2:    misaligned = (a != 2'd0);
         default: misaligned = 1'b0;
      endcase
   end

   // Extract and extend the addressed lane of the returned load word
   always_comb begin
      ld_byte = mem_rdata[{ld_off_q, 3'b000} +: 8];
      ld_half = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (ld_f3_q)
         3'd0:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         3'd4:    ld_fmt = {24'd0, ld_byte};
         3'd1:    ld_fmt = {{16{ld_half[15]}}, ld_half};
         3'd5:    ld_fmt = {16'd0, ld_half};
         default: ld_fmt = mem_rdata;
      endcase
   end

   // Next-state and next-output computation for the IDLE/REQ/RESP sequencer
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      wb_vld_d    = 1'b0;
      wb_we_d     = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      lsu_err_d   = 1'b0;
      ld_f3_d     = ld_f3_q;
      ld_off_d    = ld_off_q;
      rd_d        = rd_q;
      case (state_q)
         IDLE: begin
            if (ex_vld) begin
               if (!(is_load || is_store)) begin
                  wb_vld_d  = 1'b1;
                  wb_data_d = ex_alu_y;
                  wb_rd_d   = ex_rd;
                  wb_we_d   = (ex_opcode != OP_BRANCH) && (ex_rd != 5'd0);
               end else if (f3_bad || misaligned) begin
                  // Retire without touching memory and flag the fault
                  wb_vld_d  = 1'b1;
                  wb_rd_d   = ex_rd;
                  wb_data_d = ex_alu_y;
                  lsu_err_d = 1'b1;
               end else begin
                  state_d    = REQ;
                  mem_req_d  = 1'b1;
                  mem_we_d   = is_store;
                  mem_addr_d = {ex_alu_y[XLEN-1:2], 2'b00};
                  ld_f3_d    = ex_funct3;
                  ld_off_d   = a;
                  rd_d       = ex_rd;
                  if (is_store) begin
                     case (ex_funct3[1:0])
                        2'd0: begin
                           mem_be_d    = 4'b0001 << a;
                           mem_wdata_d = {4{ex_rs2[7:0]}};
                        end
                        2'd1: begin
                           mem_be_d    = a[1] ? 4'b1100 : 4'b0011;
                           mem_wdata_d = {2{ex_rs2[15:0]}};
                        end
                        default: begin
                           mem_be_d    = 4'hF;
                           mem_wdata_d = ex_rs2;
                        end
                     endcase
                  end else begin
                     mem_be_d    = 4'hF;
                     mem_wdata_d = '0;
                  end
               end
            end
         end
         REQ: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               if (mem_we_q) begin
                  wb_vld_d = 1'b1;
                  wb_rd_d  = rd_q;
                  state_d  = IDLE;
               end else begin
                  state_d  = RESP;
               end
            end
         end
         RESP: begin
            if (mem_rvld) begin
               wb_vld_d  = 1'b1;
               wb_data_d = ld_fmt;
               wb_rd_d   = rd_q;
               wb_we_d   = (rd_q != 5'd0);
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         wb_vld_q    <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         lsu_err_q   <= 1'b0;
         ld_f3_q     <= '0;
         ld_off_q    <= '0;
         rd_q        <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         wb_vld_q    <= wb_vld_d;
         wb_we_q     <= wb_we_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         lsu_err_q   <= lsu_err_d;
         ld_f3_q     <= ld_f3_d;
         ld_off_q    <= ld_off_d;
         rd_q        <= rd_d;
      end
   end

   assign ex_rdy    = (state_q == IDLE);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign wb_vld    = wb_vld_q;
   assign wb_we     = wb_we_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign lsu_err   = lsu_err_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_lsu
// Purpose  : Self-checking bench for memory_lsu: directed scenarios plus a
//            randomized instruction stream against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_lsu;

   localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] C_OP_STORE  = 7'b0100011;
   localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] C_OP_ALU    = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_vld = 1'b0;
   logic        ex_rdy;
   logic [6:0]  ex_opcode = '0;
   logic [2:0]  ex_funct3 = '0;
   logic [31:0] ex_alu_y = '0;
   logic [31:0] ex_rs2 = '0;
   logic [4:0]  ex_rd = '0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt = 1'b0;
   logic        mem_rvld = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        wb_vld, wb_we, lsu_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;

   memory_lsu dut (
      .clk(clk), .rst_n(rst_n),
      .ex_vld(ex_vld), .ex_rdy(ex_rdy), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .ex_alu_y(ex_alu_y), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
      .wb_vld(wb_vld), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .lsu_err(lsu_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_legal(input bit st, input int f3, input int a);
      int sz;
      if (st && f3 > 2) return 0;
      if (!st && (f3 == 3 || f3 == 6 || f3 == 7)) return 0;
      sz = f3 % 4;
      if (sz == 1 && (a % 2) != 0) return 0;
      if (sz == 2 && a != 0) return 0;
      return 1;
   endfunction

   function automatic logic [31:0] model_load(input int f3, input int a, input logic [31:0] w);
      longint word, b, h;
      word = longint'(w);
      b    = (word >> (8 * a)) & 255;
      h    = (word >> (16 * (a / 2))) & 65535;
      case (f3)
         0:       return 32'((b >= 128) ? b - 256 : b);
         4:       return 32'(b);
         1:       return 32'((h >= 32768) ? h - 65536 : h);
         5:       return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input int f3, input int a);
      case (f3)
         0:       return 4'(1 << a);
         1:       return 4'(3 << a);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input int f3, input logic [31:0] rs2);
      case (f3)
         0:       return (rs2 & 32'hFF) * 32'h0101_0101;
         1:       return (rs2 & 32'hFFFF) * 32'h0001_0001;
         default: return rs2;
      endcase
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] y,
                        input logic [31:0] rs2, input logic [4:0] rd);
      chk("ex_rdy_before_issue", {31'd0, ex_rdy}, 32'd1);
      ex_vld = 1'b1; ex_opcode = op; ex_funct3 = f3; ex_alu_y = y; ex_rs2 = rs2; ex_rd = rd;
      step();
      ex_vld = 1'b0;
   endtask

   task automatic alu_op(input logic [6:0] op, input logic [31:0] y, input logic [4:0] rd);
      issue(op, 3'd0, y, 32'd0, rd);
      chk("alu_wb_vld", {31'd0, wb_vld}, 32'd1);
      chk("alu_wb_we", {31'd0, wb_we}, {31'd0, (op != C_OP_BRANCH) && (rd != 0)});
      chk("alu_wb_rd", {27'd0, wb_rd}, {27'd0, rd});
      chk("alu_wb_data", wb_data, y);
      chk("alu_err", {31'd0, lsu_err}, 32'd0);
   endtask

   task automatic do_mem(input bit st, input logic [2:0] f3, input logic [31:0] y,
                         input logic [31:0] rs2, input logic [4:0] rd,
                         input int gnt_dly, input int rvld_dly, input logic [31:0] rdata);
      int a;
      logic [31:0] exp_addr;
      a = int'(y % 4);
      exp_addr = y - (y % 4);
      issue(st ? C_OP_STORE : C_OP_LOAD, f3, y, rs2, rd);
      if (!model_legal(st, int'(f3), a)) begin
         chk("bad_no_req", {31'd0, mem_req}, 32'd0);
         chk("bad_wb_vld", {31'd0, wb_vld}, 32'd1);
         chk("bad_wb_we", {31'd0, wb_we}, 32'd0);
         chk("bad_err", {31'd0, lsu_err}, 32'd1);
         chk("bad_rdy", {31'd0, ex_rdy}, 32'd1);
         step();
         chk("bad_err_pulse", {31'd0, lsu_err}, 32'd0);
         chk("bad_wb_pulse", {31'd0, wb_vld}, 32'd0);
         return;
      end
      for (int k = 0; k <= gnt_dly; k++) begin
         chk("req", {31'd0, mem_req}, 32'd1);
         chk("req_we", {31'd0, mem_we}, {31'd0, st});
         chk("req_addr", mem_addr, exp_addr);
         chk("req_be", {28'd0, mem_be}, st ? {28'd0, model_be(int'(f3), a)} : 32'hF);
         if (st) chk("req_wdata", mem_wdata, model_wdata(int'(f3), rs2));
         chk("req_rdy", {31'd0, ex_rdy}, 32'd0);
         chk("req_wb", {31'd0, wb_vld}, 32'd0);
         if (k < gnt_dly) begin
            // Spurious response while not waiting for one must be ignored
            mem_rvld = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            step();
            mem_rvld = 1'b0;
         end
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("gnt_req_drop", {31'd0, mem_req}, 32'd0);
      if (st) begin
         chk("st_wb_vld", {31'd0, wb_vld}, 32'd1);
         chk("st_wb_we", {31'd0, wb_we}, 32'd0);
         chk("st_rdy", {31'd0, ex_rdy}, 32'd1);
         return;
      end
      chk("ld_wait_wb", {31'd0, wb_vld}, 32'd0);
      for (int k = 0; k < rvld_dly; k++) begin
         step();
         chk("ld_wait_wb", {31'd0, wb_vld}, 32'd0);
         chk("ld_wait_rdy", {31'd0, ex_rdy}, 32'd0);
      end
      mem_rvld = 1'b1; mem_rdata = rdata;
      step();
      mem_rvld = 1'b0; mem_rdata = $urandom;
      chk("ld_wb_vld", {31'd0, wb_vld}, 32'd1);
      chk("ld_wb_data", wb_data, model_load(int'(f3), a, rdata));
      chk("ld_wb_we", {31'd0, wb_we}, {31'd0, rd != 0});
      chk("ld_wb_rd", {27'd0, wb_rd}, {27'd0, rd});
      chk("ld_rdy", {31'd0, ex_rdy}, 32'd1);
      chk("ld_err", {31'd0, lsu_err}, 32'd0);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_wb_vld", {31'd0, wb_vld}, 32'd0);
      chk("rst_err", {31'd0, lsu_err}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_be", {28'd0, mem_be}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      chk("rst_rdy", {31'd0, ex_rdy}, 32'd1);
      step(); step();
      rst_n = 1'b1;
      step();

      // ALU op and back-to-back retirement
      alu_op(C_OP_ALU, 32'h1234, 5'd5);
      alu_op(C_OP_ALU, 32'hDEAD_BEEF, 5'd6);
      alu_op(C_OP_ALU, 32'h0000_0042, 5'd0);
      alu_op(C_OP_BRANCH, 32'h0000_0100, 5'd9);
      step();
      chk("alu_wb_pulse", {31'd0, wb_vld}, 32'd0);

      // Load formatting
      do_mem(0, 3'd0, 32'h103, 32'd0, 5'd1, 0, 0, 32'h80FF_7F01);
      do_mem(0, 3'd4, 32'h103, 32'd0, 5'd2, 0, 0, 32'h80FF_7F01);
      do_mem(0, 3'd1, 32'h102, 32'd0, 5'd3, 0, 0, 32'h80FF_7F01);
      do_mem(0, 3'd2, 32'h100, 32'd0, 5'd4, 0, 2, 32'h80FF_7F01);

      // Stores, including a long grant stall
      do_mem(1, 3'd0, 32'h201, 32'hAABB_CCDD, 5'd1, 0, 0, 32'd0);
      do_mem(1, 3'd1, 32'h202, 32'hAABB_CCDD, 5'd1, 5, 0, 32'd0);

      // Misaligned access
      do_mem(0, 3'd2, 32'h102, 32'd0, 5'd7, 0, 0, 32'd0);
      do_mem(1, 3'd1, 32'h101, 32'h1111_2222, 5'd7, 0, 0, 32'd0);

      // Load to x0
      do_mem(0, 3'd2, 32'h400, 32'd0, 5'd0, 1, 1, 32'h1357_9BDF);

      // Reset while in REQ
      issue(C_OP_LOAD, 3'd2, 32'h300, 32'd0, 5'd8);
      chk("rq_req", {31'd0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rq_rst_req", {31'd0, mem_req}, 32'd0);
      chk("rq_rst_rdy", {31'd0, ex_rdy}, 32'd1);
      rst_n = 1'b1;
      mem_rvld = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      step();
      chk("rq_stale_wb", {31'd0, wb_vld}, 32'd0);
      step();
      chk("rq_stale_wb", {31'd0, wb_vld}, 32'd0);
      mem_rvld = 1'b0;
      alu_op(C_OP_ALU, 32'h0000_5555, 5'd10);

      // Reset while in RESP
      issue(C_OP_LOAD, 3'd0, 32'h305, 32'd0, 5'd11);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("rs_rdy_wait", {31'd0, ex_rdy}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_rst_req", {31'd0, mem_req}, 32'd0);
      chk("rs_rst_rdy", {31'd0, ex_rdy}, 32'd1);
      rst_n = 1'b1;
      mem_rvld = 1'b1; mem_rdata = 32'h0000_8000;
      step();
      mem_rvld = 1'b0;
      chk("rs_stale_wb", {31'd0, wb_vld}, 32'd0);
      do_mem(0, 3'd5, 32'h306, 32'd0, 5'd12, 0, 0, 32'h8001_0000);

      // Randomized instruction stream
      for (int i = 0; i < 60; i++) begin
         int kind;
         logic [31:0] y, rs2, rdata;
         logic [4:0]  rd;
         logic [2:0]  f3;
         kind  = $urandom_range(0, 3);
         y     = $urandom;
         rs2   = $urandom;
         rdata = $urandom;
         rd    = 5'($urandom_range(0, 31));
         f3    = 3'($urandom_range(0, 7));
         case (kind)
            0: alu_op(C_OP_ALU, y, rd);
            1: alu_op(C_OP_BRANCH, y, rd);
            2: do_mem(0, f3, y, rs2, rd, $urandom_range(0, 3), $urandom_range(0, 3), rdata);
            default: do_mem(1, f3, y, rs2, rd, $urandom_range(0, 3), 0, rdata);
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
